// File: rtl/first_nios2_system_cpu_oci_dct_sequencer_pkg.sv
// Shared widths and FSM state encoding for the OCI trace-code sequencer.
package first_nios2_system_cpu_oci_dct_sequencer_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned BUF_W  = 30;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TM_W   = 34;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StEmit    = 2'd1,
    StFinal   = 2'd2,
    StDone    = 2'd3
  } dct_state_e;

endpackage

// File: rtl/first_nios2_system_cpu_oci_dct_sequencer.sv
// Packs 2-bit trace codes into 30-bit words and hands them to trace memory,
// emitting on full buffer, flush, or end of capture.
module first_nios2_system_cpu_oci_dct_sequencer
  import first_nios2_system_cpu_oci_dct_sequencer_pkg::*;
#(
  parameter int unsigned FULL_COUNT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trc_valid,
  input  logic [CODE_W-1:0] trc_code,
  output logic              trc_ready,
  input  logic              flush_req,
  input  logic              stop_req,
  output logic              tm_valid,
  output logic [TM_W-1:0]   tm_data,
  input  logic              tm_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  dct_state_e        state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TM_W-1:0]   tm_data_q, tm_data_d;
  logic              stop_q, stop_d;

  logic              accept;
  logic [BUF_W-1:0]  buf_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  assign trc_ready      = (state_q == StCollect) && !stop_q && !reset;
  assign tm_valid       = (state_q == StEmit) || (state_q == StFinal);
  assign tm_data        = tm_data_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = stop_q && (state_q != StDone);
  assign test_has_ended = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    tm_data_d = tm_data_q;
    stop_d    = stop_q || (stop_req && (state_q != StDone));

    accept  = trc_valid && trc_ready;
    buf_nxt = accept ? {buf_q[BUF_W-CODE_W-1:0], trc_code} : buf_q;
    cnt_nxt = cnt_q + {{(CNT_W-1){1'b0}}, accept};

    unique case (state_q)
      StCollect: begin
        if (stop_q) begin
          // Stop acts one cycle after its pulse; acceptance is already blocked.
          if (cnt_q != '0) begin
            tm_data_d = {cnt_q, buf_q};
            buf_d     = '0;
            cnt_d     = '0;
            state_d   = StFinal;
          end else begin
            state_d = StDone;
          end
        end else if ((accept && (cnt_nxt == CNT_W'(FULL_COUNT))) ||
                     (flush_req && !stop_req && (cnt_nxt != '0))) begin
          tm_data_d = {cnt_nxt, buf_nxt};
          buf_d     = '0;
          cnt_d     = '0;
          state_d   = StEmit;
        end else begin
          buf_d = buf_nxt;
          cnt_d = cnt_nxt;
        end
      end
      StEmit: begin
        if (tm_ready) state_d = stop_q ? StDone : StCollect;
      end
      StFinal: begin
        if (tm_ready) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StCollect;
      buf_q     <= '0;
      cnt_q     <= '0;
      tm_data_q <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      tm_data_q <= tm_data_d;
      stop_q    <= stop_d;
    end
  end

endmodule

// File: tb/tb_first_nios2_system_cpu_oci_dct_sequencer.sv
// Directed and randomized bench for the trace-code sequencer, checked each cycle
// against a queue-based model of the packing and handshake rules.
module tb_first_nios2_system_cpu_oci_dct_sequencer;

  localparam int unsigned FullCount = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        trc_valid;
  logic [1:0]  trc_code;
  logic        trc_ready;
  logic        flush_req;
  logic        stop_req;
  logic        tm_valid;
  logic [33:0] tm_data;
  logic        tm_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int checks = 0;
  int failures = 0;

  // Model: codes held in the live buffer, the word owed to trace memory, stop/done flags.
  int          m_codes[$];
  logic [33:0] m_word;
  bit          m_wv;
  bit          m_stop;
  bit          m_done;

  first_nios2_system_cpu_oci_dct_sequencer #(.FULL_COUNT(FullCount)) dut (
    .clk            (clk),
    .reset          (reset),
    .trc_valid      (trc_valid),
    .trc_code       (trc_code),
    .trc_ready      (trc_ready),
    .flush_req      (flush_req),
    .stop_req       (stop_req),
    .tm_valid       (tm_valid),
    .tm_data        (tm_data),
    .tm_ready       (tm_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] model_buf();
    logic [63:0] v = 0;
    foreach (m_codes[i]) v = v * 4 + 64'(m_codes[i]);
    return v[29:0];
  endfunction

  function automatic bit model_ready();
    return !reset && !m_wv && !m_stop && !m_done;
  endfunction

  task automatic snapshot();
    m_word = {4'(m_codes.size()), model_buf()};
    m_codes.delete();
    m_wv = 1'b1;
  endtask

  task automatic model_step();
    bit accept;
    bit stop_new;
    if (reset) begin
      m_codes.delete();
      m_word = '0;
      m_wv   = 1'b0;
      m_stop = 1'b0;
      m_done = 1'b0;
      return;
    end
    if (m_done) return;
    accept   = trc_valid && model_ready();
    stop_new = m_stop || stop_req;
    if (m_wv) begin
      if (tm_ready) begin
        m_wv = 1'b0;
        if (m_stop) m_done = 1'b1;
      end
    end else if (m_stop) begin
      if (m_codes.size() > 0) snapshot();
      else m_done = 1'b1;
    end else begin
      if (accept) m_codes.push_back(int'(trc_code));
      if (m_codes.size() == FullCount) snapshot();
      else if (flush_req && !stop_req && m_codes.size() > 0) snapshot();
    end
    m_stop = stop_new;
  endtask

  task automatic check_all();
    check_val("trc_ready", trc_ready, model_ready());
    check_val("tm_valid", tm_valid, m_wv && !m_done);
    check_val("tm_data", tm_data, m_word);
    check_val("dct_buffer", dct_buffer, model_buf());
    check_val("dct_count", dct_count, m_codes.size());
    check_val("test_ending", test_ending, m_stop && !m_done);
    check_val("test_has_ended", test_has_ended, m_done);
  endtask

  // One clock: check mid-cycle, advance the model on the edge, return just after it.
  task automatic tick();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trc_valid = 0; trc_code = 0; flush_req = 0; stop_req = 0; tm_ready = 1;
  endtask

  task automatic push_code(input logic [1:0] c);
    trc_valid = 1; trc_code = c;
    tick();
    trc_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    m_word = '0; m_wv = 0; m_stop = 0; m_done = 0;
    tick();
    tick();
    check_val("rst_count", dct_count, 0);
    check_val("rst_tm_valid", tm_valid, 0);
    reset = 0;
    tick();

    // Full buffer of 2'b01 codes emits automatically.
    for (int i = 0; i < 15; i++) push_code(2'b01);
    check_val("full_word", tm_data, 34'h3D5555555);
    check_val("full_valid", tm_valid, 1);
    check_val("full_cnt_clr", dct_count, 0);
    tick();

    // Partial flush.
    push_code(2'b11);
    push_code(2'b00);
    push_code(2'b10);
    flush_req = 1;
    tick();
    flush_req = 0;
    check_val("flush_word", tm_data, {4'd3, 30'h0000_0032});
    check_val("flush_busy", trc_ready, 0);
    tick();
    check_val("flush_resume", trc_ready, 1);

    // Back-pressure during EMIT.
    push_code(2'b10);
    push_code(2'b01);
    flush_req = 1;
    tick();
    flush_req = 0;
    tm_ready  = 0;
    for (int i = 0; i < 5; i++) tick();
    check_val("bp_hold", tm_data, {4'd2, 30'h0000_0009});
    tm_ready = 1;
    tick();

    // Stop with two codes buffered.
    push_code(2'b11);
    push_code(2'b01);
    stop_req = 1;
    flush_req = 1;
    tick();
    stop_req = 0; flush_req = 0;
    check_val("stop_ending", test_ending, 1);
    tick();
    check_val("final_valid", tm_valid, 1);
    check_val("final_cnt", tm_data[33:30], 2);
    tick();
    check_val("stop_ended", test_has_ended, 1);
    check_val("stop_ending_clr", test_ending, 0);
    tick();
    do_reset();

    // Stop with empty buffer.
    stop_req = 1;
    tick();
    stop_req = 0;
    tick();
    check_val("empty_stop_ended", test_has_ended, 1);
    check_val("empty_stop_nowrd", tm_valid, 0);
    do_reset();

    // Reset while FINAL waits on trace memory.
    push_code(2'b10);
    stop_req = 1;
    tick();
    stop_req = 0;
    tm_ready = 0;
    tick();
    tick();
    reset = 1;
    tick();
    check_val("rst_final_valid", tm_valid, 0);
    check_val("rst_final_data", tm_data, 0);
    check_val("rst_final_ready", trc_ready, 0);
    reset = 0;
    #1;
    check_val("post_rst_ready", trc_ready, 1);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      trc_valid = ($urandom_range(0, 99) < 70);
      trc_code  = 2'($urandom);
      tm_ready  = ($urandom_range(0, 99) < 65);
      flush_req = ($urandom_range(0, 99) < 8);
      stop_req  = ($urandom_range(0, 199) < 2);
      reset     = ($urandom_range(0, 299) < 1) || (m_done && $urandom_range(0, 9) == 0);
      tick();
    end
    idle();
    reset = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
